// File: rtl/bcd_counter_cascade_if.sv
// Control and status bundle for bcd_counter_cascade.
// master drives count controls and observes the BCD value and flags; slave is the counter.
interface bcd_counter_cascade_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up_dn;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  tc;
    logic                  wrap;
    logic                  load_err;

    modport master (
        output en, up_dn, load, load_val,
        input  count, tc, wrap, load_err
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output count, tc, wrap, load_err
    );
endinterface

// File: rtl/bcd_counter_cascade.sv
// Cascaded up/down BCD counter with load, terminal count and wrap pulse; BCD_COUNTER_SATURATE_EN holds at the ends.
// Latency: count/wrap/load_err update one clk after en/load are sampled; tc is combinational.
// Backpressure: none; en acts as a per-cycle advance qualifier and tc can feed a downstream en.
module bcd_counter_cascade #(
    parameter int         DIGITS  = 4,
    parameter logic [3:0] RST_VAL = 4'd0
) (
    input  logic                      clk,
    input  logic                      rst,
    bcd_counter_cascade_if.slave      bus
);
    localparam int W = 4 * DIGITS;
`ifdef BCD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic [W-1:0] count_q;
    logic [W-1:0] count_nxt;
    logic [W-1:0] load_san;
    logic         wrap_q;
    logic         load_err_q;
    logic         all9;
    logic         all0;
    logic         term;
    logic         tc_c;
    logic         err_c;
    logic         carry;
    logic [3:0]   dig;
    logic [3:0]   ld_dig;

    always_comb begin
        all9 = 1'b1;
        all0 = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count_q[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (count_q[4*i +: 4] != 4'd0) all0 = 1'b0;
        end
    end

    assign term = bus.up_dn ? all9 : all0;
    assign tc_c = bus.en & ~bus.load & term;

    // Out-of-range load digits are replaced with 0 so state never leaves BCD.
    always_comb begin
        load_san = '0;
        err_c    = 1'b0;
        ld_dig   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            ld_dig = bus.load_val[4*i +: 4];
            if (ld_dig > 4'd9) err_c = 1'b1;
            else               load_san[4*i +: 4] = ld_dig;
        end
    end

    // Ripple the decade carry/borrow from digit 0 upward.
    always_comb begin
        count_nxt = count_q;
        carry     = 1'b1;
        dig       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            if (carry) begin
                if (bus.up_dn) count_nxt[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                else           count_nxt[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end
            carry = carry & (bus.up_dn ? (dig == 4'd9) : (dig == 4'd0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= {DIGITS{RST_VAL}};
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else if (bus.load) begin
            count_q    <= load_san;
            wrap_q     <= 1'b0;
            load_err_q <= err_c;
        end else begin
            if (bus.en && !(SAT && term)) count_q <= count_nxt;
            wrap_q     <= SAT ? 1'b0 : tc_c;
            load_err_q <= 1'b0;
        end
    end

    assign bus.count    = count_q;
    assign bus.tc       = tc_c;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_bcd_counter_cascade.sv
// Randomised and directed bench for a 2-digit bcd_counter_cascade (RST_VAL=5) against an integer-valued model.
module tb_bcd_counter_cascade;
    localparam int DIGITS = 2;
    localparam int RSTV   = 5;
    localparam int MAXV   = 99;
`ifdef BCD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bcd_counter_cascade_if #(.DIGITS(DIGITS)) bus ();

    bcd_counter_cascade #(.DIGITS(DIGITS), .RST_VAL(4'(RSTV))) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int chk = 0;
    int pass = 0;

    int m_v = 0;
    bit m_wrap = 1'b0;
    bit m_err = 1'b0;
    bit m_tc = 1'b0;
    logic obs_tc;

    function automatic logic [7:0] to_bcd(input int v);
        to_bcd = {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int sanit(input logic [3:0] n);
        sanit = (n > 4'd9) ? 0 : int'(n);
    endfunction

    task automatic drive(input bit r, input bit e, input bit u, input bit l, input logic [7:0] lv);
        rst          = r;
        bus.en       = e;
        bus.up_dn    = u;
        bus.load     = l;
        bus.load_val = lv;
    endtask

    // Advance one clock: sample tc before the edge, update the model at the edge.
    task automatic tick();
        int nv;
        @(negedge clk);
        obs_tc = bus.tc;
        m_tc = bus.en && !bus.load && (bus.up_dn ? (m_v == MAXV) : (m_v == 0));
        @(posedge clk);
        if (rst) begin
            m_v = RSTV * 11; m_wrap = 0; m_err = 0;
        end else if (bus.load) begin
            m_v = sanit(bus.load_val[7:4]) * 10 + sanit(bus.load_val[3:0]);
            m_err = (bus.load_val[7:4] > 4'd9) || (bus.load_val[3:0] > 4'd9);
            m_wrap = 0;
        end else begin
            m_err = 0;
            m_wrap = m_tc && !SAT;
            if (bus.en) begin
                if (bus.up_dn) nv = (m_v == MAXV) ? (SAT ? MAXV : 0) : m_v + 1;
                else           nv = (m_v == 0) ? (SAT ? 0 : MAXV) : m_v - 1;
                m_v = nv;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 0, 8'h00);
        tick();
        chk++; if (bus.count !== 8'h55) $display("FAIL reset_count got %h want 55", bus.count); else pass++;
        chk++; if (bus.wrap !== 1'b0) $display("FAIL reset_wrap got %b want 0", bus.wrap); else pass++;
        chk++; if (bus.load_err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.load_err); else pass++;
    endtask

    task automatic test_up_wrap();
        int ntc = 0, nwrap = 0, bad = 0;
        drive(0, 0, 1, 1, 8'h00);
        tick();
        chk++; if (bus.count !== 8'h00) $display("FAIL up_load00 got %h want 00", bus.count); else pass++;
        drive(0, 1, 1, 0, 8'h00);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (obs_tc) ntc++;
            if (bus.wrap) begin
                nwrap++;
                if (bus.count !== 8'h00) bad++;
            end
            chk++; if (bus.count !== to_bcd(m_v) || obs_tc !== m_tc || bus.wrap !== m_wrap)
                $display("FAIL up_step%0d got %h/%b/%b want %h/%b/%b", i, bus.count, obs_tc, bus.wrap, to_bcd(m_v), m_tc, m_wrap);
            else pass++;
        end
        chk++; if (ntc !== 1) $display("FAIL up_tc_cycles got %0d want 1", ntc); else pass++;
        chk++; if (nwrap !== (SAT ? 0 : 1) || bad !== 0)
            $display("FAIL up_wrap_cycles got %0d (misaligned %0d) want %0d", nwrap, bad, SAT ? 0 : 1);
        else pass++;
    endtask

    task automatic test_down_wrap();
        logic [7:0] exp_seq [7];
        logic [7:0] exp_w;
        if (SAT) exp_seq = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
        else     exp_seq = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99, 8'h98};
        drive(0, 0, 0, 1, 8'h05);
        tick();
        drive(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) begin
            tick();
            exp_w = (i == 5 && !SAT) ? 8'h01 : 8'h00;
            chk++; if (bus.count !== exp_seq[i] || bus.count !== to_bcd(m_v))
                $display("FAIL down_step%0d got %h want %h", i, bus.count, exp_seq[i]);
            else pass++;
            chk++; if ({7'd0, bus.wrap} !== exp_w || obs_tc !== m_tc)
                $display("FAIL down_flags%0d got wrap %b tc %b want wrap %0d tc %b", i, bus.wrap, obs_tc, exp_w, m_tc);
            else pass++;
        end
    endtask

    task automatic test_load();
        drive(0, 1, 1, 1, 8'h47);
        tick();
        chk++; if (bus.count !== 8'h47 || bus.load_err !== 1'b0 || obs_tc !== 1'b0)
            $display("FAIL load_47 got %h err %b tc %b want 47 err 0 tc 0", bus.count, bus.load_err, obs_tc);
        else pass++;
        drive(0, 0, 1, 1, 8'hA3);
        tick();
        chk++; if (bus.count !== 8'h03 || bus.load_err !== 1'b1)
            $display("FAIL load_A3 got %h err %b want 03 err 1", bus.count, bus.load_err);
        else pass++;
        drive(0, 0, 1, 0, 8'h00);
        tick();
        chk++; if (bus.load_err !== 1'b0) $display("FAIL load_err_pulse got %b want 0", bus.load_err); else pass++;
        drive(0, 1, 0, 1, 8'hFF);
        tick();
        chk++; if (bus.count !== 8'h00 || bus.load_err !== 1'b1 || bus.wrap !== 1'b0)
            $display("FAIL load_FF got %h err %b wrap %b want 00 1 0", bus.count, bus.load_err, bus.wrap);
        else pass++;
    endtask

    task automatic test_hold_dir();
        logic [7:0] seq [4];
        seq = '{8'h63, 8'h62, 8'h63, 8'h62};
        drive(0, 0, 1, 1, 8'h62);
        tick();
        drive(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk++; if (bus.count !== 8'h62) $display("FAIL hold%0d got %h want 62", i, bus.count); else pass++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, (i % 2) == 0, 0, 8'h00);
            tick();
            chk++; if (bus.count !== seq[i] || bus.count !== to_bcd(m_v))
                $display("FAIL dir%0d got %h want %h", i, bus.count, seq[i]);
            else pass++;
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 1, 1, 8'h38);
        tick();
        drive(1, 1, 1, 0, 8'h00);
        tick();
        chk++; if (bus.count !== 8'h55 || bus.wrap !== 1'b0 || bus.load_err !== 1'b0)
            $display("FAIL rst_mid got %h/%b/%b want 55/0/0", bus.count, bus.wrap, bus.load_err);
        else pass++;
        drive(1, 1, 1, 1, 8'hA9);
        tick();
        chk++; if (bus.count !== 8'h55 || bus.load_err !== 1'b0)
            $display("FAIL rst_over_load got %h err %b want 55 err 0", bus.count, bus.load_err);
        else pass++;
        drive(0, 1, 1, 0, 8'h00);
        tick();
        chk++; if (bus.count !== 8'h56) $display("FAIL rst_resume got %h want 56", bus.count); else pass++;
    endtask

    task automatic test_ends();
        drive(0, 0, 1, 1, 8'h98);
        tick();
        drive(0, 1, 1, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk++; if (bus.count !== to_bcd(m_v) || obs_tc !== m_tc || bus.wrap !== m_wrap)
                $display("FAIL end_up%0d got %h/%b/%b want %h/%b/%b", i, bus.count, obs_tc, bus.wrap, to_bcd(m_v), m_tc, m_wrap);
            else pass++;
        end
        drive(0, 0, 0, 1, 8'h01);
        tick();
        drive(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk++; if (bus.count !== to_bcd(m_v) || bus.wrap !== m_wrap)
                $display("FAIL end_dn%0d got %h/%b want %h/%b", i, bus.count, bus.wrap, to_bcd(m_v), m_wrap);
            else pass++;
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0, 8'($urandom));
            tick();
            if (bus.count !== to_bcd(m_v) || obs_tc !== m_tc || bus.wrap !== m_wrap || bus.load_err !== m_err) begin
                errs++;
                if (errs < 5)
                    $display("FAIL rand%0d got %h/%b/%b/%b want %h/%b/%b/%b", i, bus.count, obs_tc, bus.wrap,
                             bus.load_err, to_bcd(m_v), m_tc, m_wrap, m_err);
            end
        end
        chk++; if (errs !== 0) $display("FAIL rand_total got %0d mismatching cycles want 0", errs); else pass++;
    endtask

    initial begin
        drive(0, 0, 1, 0, 8'h00);
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load();
        test_hold_dir();
        test_reset_mid();
        test_ends();
        test_random();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bcd_counter_cascade.md
Name: bcd_counter_cascade

Overview:
- Parametrised multi-digit BCD counter, next generation of the single-digit decade counter.
- Counts up or down in decimal across DIGITS cascaded decade stages.
- Supports count enable, parallel load, a terminal-count flag and a registered wrap pulse.
- Used as the event/timebase counter feeding display and timer logic.

Parameters:
- DIGITS, 4, number of cascaded BCD digits (1..8); count width = 4*DIGITS.
- RST_VAL, 0, reset value per digit, 0..9; all digits reset to this value.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable; advance one count per cycle when high.
- up_dn  in  1  direction: 1 = up, 0 = down; sampled every cycle.
- load  in  1  parallel load strobe.
- load_val  in  4*DIGITS  BCD load value; digit 0 = bits [3:0].
- count  out  4*DIGITS  current BCD value; digit 0 least significant; registered.
- tc  out  1  terminal count, combinational; details under Behaviour.
- wrap  out  1  registered one-cycle pulse, set the cycle after a wrap.
- load_err  out  1  registered one-cycle pulse, set when a loaded digit was >9.

Behaviour:
- Priority each cycle: rst > load > en. With en=0 and no load, count holds.
- Reset:
  - Every digit = RST_VAL.
  - wrap = 0, load_err = 0.
  - Reset mid-count or mid-load overrides everything in that cycle.
- Load:
  - Digit i takes load_val[4i+3:4i] if that value is ≤9; otherwise it takes 0.
  - load_err is 1 in the following cycle if any digit was >9, else 0.
  - en is ignored in the load cycle. wrap = 0 in the cycle after a load.
- Up count (en=1, up_dn=1):
  - Digit 0 always steps.
  - Digit i>0 steps only when all lower digits equal 9.
  - A stepping digit at 9 becomes 0; otherwise it increments by 1.
- Down count (en=1, up_dn=0):
  - Digit i>0 steps only when all lower digits equal 0.
  - A stepping digit at 0 becomes 9; otherwise it decrements by 1.
- Wrap-around:
  - Up: all-9s → all-0s. Down: all-0s → all-9s.
- tc:
  - tc = en & ((up_dn & all digits 9) | (~up_dn & all digits 0)).
  - tc is forced to 0 when load=1.
  - Suitable as en for a further external cascade.
- wrap: registered copy of tc, high the cycle after the wrapping edge.
- Illegal digit codes (>9) can arise only from load, and are sanitised there. Internal state never leaves BCD.
- Direction change mid-count takes effect on the same edge. No extra latency, no skip.
- Latency: count updates one clock after en/load sampled.

Optional Feature:
- Macro: BCD_COUNTER_SATURATE_EN.
- Defined:
  - Counter saturates instead of wrapping: up at all-9s holds, down at all-0s holds.
  - tc still asserts at the terminal value with en=1.
  - wrap never asserts; it is tied 0.
- Undefined: wrap-around behaviour as above.

Test Plan (DIGITS=2, RST_VAL=0 unless stated):
- Up count and wrap:
  - rst pulse, then en=1, up_dn=1 for 100 cycles → count steps 00,01…09,10…99,00.
  - tc=1 only while count=99.
  - wrap=1 exactly one cycle, coincident with count=00.
- Down count and wrap: load 05, then en=1, up_dn=0 → 04,03,02,01,00,99,98; tc=1 at 00; wrap pulses with 99.
- Load priority and sanitising:
  - load_val=0x47 with en=1 in the same cycle → count=47, not 48.
  - load_val=0xA3 → count=03, load_err=1 for one cycle.
- Hold and direction change:
  - en=0 for 5 cycles at 62 → count holds 62.
  - Then en=1 with up_dn toggling each cycle → 63,62,63,62.
- Reset mid-operation:
  - With RST_VAL=5, count at 38 with en=1, assert rst one cycle → count=55 next edge, wrap=0, load_err=0.
  - Counting resumes 56 after rst deasserts.
- Saturate build (BCD_COUNTER_SATURATE_EN defined):
  - Up from 98 → 99,99,99 with tc=1 and wrap=0.
  - Down from 01 → 00,00 with wrap=0.
